// File: rtl/serial_operand_tx.sv
// Parallel-to-serial operand transmitter: emits A/B as MSB-first bit pairs under valid/ready.
// Define SER_TX_PARITY_EN to append one XOR-parity beat after the W data beats.
module serial_operand_tx #(
  parameter int unsigned W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [W-1:0] A_IN,
  input  logic [W-1:0] B_IN,
  input  logic         READY,
  output logic         A_BIT,
  output logic         B_BIT,
  output logic         VALID,
  output logic         LAST,
  output logic         BUSY,
  output logic         DONE
);

`ifdef SER_TX_PARITY_EN
  localparam int unsigned SW = W + 1;
`else
  localparam int unsigned SW = W;
`endif
  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [CW-1:0] CntLoad = CW'(SW - 1);

  typedef enum logic [1:0] {StIdle, StShift, StFinish} state_t;

  state_t         state;
  logic [SW-1:0]  a_sr;
  logic [SW-1:0]  b_sr;
  logic [CW-1:0]  cnt;
  logic [SW-1:0]  a_load;
  logic [SW-1:0]  b_load;

  // Parity is folded into the shift register so the extra beat falls out of the same shift.
`ifdef SER_TX_PARITY_EN
  assign a_load = {A_IN, ^A_IN};
  assign b_load = {B_IN, ^B_IN};
`else
  assign a_load = A_IN;
  assign b_load = B_IN;
`endif

  // Fully shifted-out registers are zero, so the MSB is 0 whenever no beat is pending.
  assign A_BIT = a_sr[SW-1];
  assign B_BIT = b_sr[SW-1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= StIdle;
      a_sr  <= '0;
      b_sr  <= '0;
      cnt   <= '0;
      VALID <= 1'b0;
      LAST  <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          DONE <= 1'b0;
          if (START) begin
            a_sr  <= a_load;
            b_sr  <= b_load;
            cnt   <= CntLoad;
            VALID <= 1'b1;
            BUSY  <= 1'b1;
            LAST  <= (SW == 1);
            state <= StShift;
          end
        end
        StShift: begin
          if (READY) begin
            a_sr <= a_sr << 1;
            b_sr <= b_sr << 1;
            if (cnt == '0) begin
              VALID <= 1'b0;
              LAST  <= 1'b0;
              DONE  <= 1'b1;
              state <= StFinish;
            end else begin
              cnt  <= cnt - CW'(1);
              LAST <= (cnt == CW'(1));
            end
          end
        end
        StFinish: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          VALID <= 1'b0;
          LAST  <= 1'b0;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_operand_tx.sv
// Randomised self-checking bench for serial_operand_tx (W=8 and W=1 instances).
module tb_serial_operand_tx;

`ifdef SER_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start, ready, a_bit, b_bit, valid, last, busy, done;
  logic [7:0] a_in, b_in;
  logic       start1, ready1, a1, b1, a_bit1, b_bit1, valid1, last1, busy1, done1;

  int total = 0;
  int bad   = 0;

  serial_operand_tx #(.W(8)) dut8 (
    .CLK(clk), .RST(rst), .START(start), .A_IN(a_in), .B_IN(b_in), .READY(ready),
    .A_BIT(a_bit), .B_BIT(b_bit), .VALID(valid), .LAST(last), .BUSY(busy), .DONE(done)
  );

  serial_operand_tx #(.W(1)) dut1 (
    .CLK(clk), .RST(rst), .START(start1), .A_IN(a1), .B_IN(b1), .READY(ready1),
    .A_BIT(a_bit1), .B_BIT(b_bit1), .VALID(valid1), .LAST(last1), .BUSY(busy1), .DONE(done1)
  );

  // Reference: beat k of a w-bit word is bit w-1-k; beat w (parity build) is XOR of the word.
  function automatic logic exp_bit(input logic [31:0] v, input int w, input int k);
    logic [31:0] m;
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (k < w) return v[w-1-k];
    return ^(v & m);
  endfunction

  // Sends one word on the W=8 instance; stalls READY for stall_len cycles when beat stall_at
  // is presented, or randomly when rand_ready is set. Returns with DONE expected visible.
  task automatic xfer8(input logic [7:0] a, input logic [7:0] b, input int stall_at,
                       input int stall_len, input bit rand_ready, input bit poke_start);
    int n, k, cyc, stalls, sc;
    logic r;
    n = 8 + PAR; k = 0; cyc = 0; stalls = 0; sc = 0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    start = 1'b1; a_in = a; b_in = b; ready = 1'b1;
    @(negedge clk);
    start = 1'b0; a_in = 8'($urandom); b_in = 8'($urandom); cyc = 1;
    while (k < n && cyc < 200) begin
      total++;
      if (valid !== 1'b1 || a_bit !== exp_bit({24'd0, a}, 8, k) ||
          b_bit !== exp_bit({24'd0, b}, 8, k) || last !== (k == n - 1)) begin
        bad++;
        $display("FAIL beat%0d a=%h b=%h: got v/a/b/l=%b%b%b%b want 1%b%b%b", k, a, b,
                 valid, a_bit, b_bit, last, exp_bit({24'd0, a}, 8, k),
                 exp_bit({24'd0, b}, 8, k), (k == n - 1));
      end
      if (k == stall_at && sc < stall_len) begin r = 1'b0; sc++; end
      else if (rand_ready) r = 1'($urandom);
      else r = 1'b1;
      if (!r) stalls++;
      if (poke_start && cyc == 2) begin start = 1'b1; a_in = 8'hFF; b_in = 8'hFF; end
      else start = 1'b0;
      ready = r;
      if (r) k++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; ready = 1'b1;
    total++;
    if (k < n) begin bad++; $display("FAIL xfer_timeout: got %0d beats want %0d", k, n); end
    total++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b1 || last !== 1'b0) begin
      bad++;
      $display("FAIL finish: got d/v/b/l=%b%b%b%b want 1010", done, valid, busy, last);
    end
    total++;
    if (cyc != n + 1 + stalls) begin
      bad++; $display("FAIL latency: got %0d want %0d", cyc, n + 1 + stalls);
    end
  endtask

  task automatic test_reset();
    int i;
    total++;
    if ({a_bit, b_bit, valid, last, busy, done} !== 6'b0) begin
      bad++; $display("FAIL reset_state: got %b want 000000", {a_bit, b_bit, valid, last, busy, done});
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); start = 1'b1; a_in = 8'hA5; b_in = 8'h3C; ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (i = 0; i < 3; i++) @(negedge clk);
    total++;
    if (valid !== 1'b1 || b_bit !== 1'b1) begin
      bad++; $display("FAIL pre_reset_beat: got v/b=%b%b want 11", valid, b_bit);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({a_bit, b_bit, valid, last, busy, done} !== 6'b0) begin
      bad++; $display("FAIL async_reset: got %b want 000000", {a_bit, b_bit, valid, last, busy, done});
    end
    @(negedge clk); rst = 1'b0;
    for (i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if (valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL post_reset_idle: got v/d/b=%b%b%b want 000", valid, done, busy);
      end
    end
  endtask

  task automatic test_basic();
    xfer8(8'hA5, 8'h3C, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    xfer8(8'hA5, 8'h3C, 2, 3, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_start();
    int i;
    xfer8(8'hA5, 8'h3C, -1, 0, 1'b0, 1'b1);
    start = 1'b1; a_in = 8'h5A; b_in = 8'hC3;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      bad++; $display("FAIL start_in_done: got busy/valid=%b%b want 00", busy, valid);
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (valid !== 1'b1 || a_bit !== 1'b0 || b_bit !== 1'b1) begin
      bad++; $display("FAIL start_after_done: got v/a/b=%b%b%b want 101", valid, a_bit, b_bit);
    end
    for (i = 0; i < 40 && done !== 1'b1; i++) @(negedge clk);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL drain_done: got %b want 1", done); end
  endtask

  task automatic test_narrow();
    int n, k, it;
    logic va, vb;
    n = 1 + PAR;
    for (it = 0; it < 6; it++) begin
      va = (it == 0) ? 1'b1 : 1'($urandom);
      vb = (it == 0) ? 1'b0 : 1'($urandom);
      @(negedge clk); start1 = 1'b1; a1 = va; b1 = vb; ready1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      for (k = 0; k < n; k++) begin
        total++;
        if (valid1 !== 1'b1 || a_bit1 !== exp_bit({31'd0, va}, 1, k) ||
            b_bit1 !== exp_bit({31'd0, vb}, 1, k) || last1 !== (k == n - 1)) begin
          bad++;
          $display("FAIL narrow_beat%0d: got v/a/b/l=%b%b%b%b want 1%b%b%b", k, valid1, a_bit1,
                   b_bit1, last1, exp_bit({31'd0, va}, 1, k), exp_bit({31'd0, vb}, 1, k),
                   (k == n - 1));
        end
        @(negedge clk);
      end
      total++;
      if (done1 !== 1'b1 || valid1 !== 1'b0) begin
        bad++; $display("FAIL narrow_done: got d/v=%b%b want 10", done1, valid1);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) xfer8(8'($urandom), 8'($urandom), -1, 0, 1'b1, 1'($urandom));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; ready = 1'b1;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; ready1 = 1'b1;
    #2;
    test_reset();
    test_basic();
    test_backpressure();
    test_ignored_start();
    test_narrow();
`ifdef SER_TX_PARITY_EN
    xfer8(8'hA5, 8'h3D, -1, 0, 1'b0, 1'b0);
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_operand_tx.md
Name: serial_operand_tx

Overview:
- Parallel-to-serial transmitter that feeds the bit-serial comparator datapath.
- Captures two W-bit operands A and B on a start request.
- Emits them as synchronous bit pairs, MSB first, one beat per accepted transfer, with a valid/ready handshake and a last-beat marker.
- Sits between the operand registers and the serial comparator's capture flip-flops, which sample on an accepted beat.

Parameters:
- W, 8, operand width in bits (legal range 1..32).

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  reset, asynchronous, active-high; clears all state immediately.
- START  input  1  load request; sampled only in IDLE.
- A_IN  input  W  operand A, captured on accepted START.
- B_IN  input  W  operand B, captured on accepted START.
- READY  input  1  downstream can accept the current beat.
- A_BIT  output  1  current serial bit of A.
- B_BIT  output  1  current serial bit of B.
- VALID  output  1  A_BIT/B_BIT hold a valid beat.
- LAST  output  1  current beat is the final beat of the word.
- BUSY  output  1  transfer in progress (any state but IDLE).
- DONE  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (async, RST=1): state=IDLE; shift registers=0; beat counter=0.
  - Outputs: A_BIT=0, B_BIT=0, VALID=0, LAST=0, BUSY=0, DONE=0.
  - Takes effect mid-transfer with no completion: no DONE and no further beats after RST deasserts.
- State machine IDLE / SHIFT / FINISH. All outputs are registered or decoded from registered state, with no combinational path from READY to outputs.
- IDLE:
  - START=1 at an edge: capture A_IN, B_IN into shift registers, counter=W-1, go to SHIFT.
  - Latency: VALID=1 in the cycle after START is sampled.
  - START=0: remain in IDLE.
- SHIFT:
  - VALID=1; A_BIT/B_BIT = MSB of the respective shift register.
  - LAST=1 when counter==0 (parity disabled).
  - Beat is transferred at an edge where VALID=1 and READY=1.
  - On transfer: shift both registers left one bit (zero fill), decrement counter.
  - If the transferred beat had LAST=1: go to FINISH.
  - READY=0: hold all outputs and state unchanged (backpressure; VALID is never withdrawn once asserted until transfer).
- FINISH: one cycle only; DONE=1, VALID=0, BUSY=1; next state IDLE.
- Transfer cost:
  - Total beats per word = W (W+1 with the parity feature).
  - Minimum cycles START-sample to DONE pulse = W+1 with READY held high.
- START while BUSY is ignored; the operands are not re-captured.
- START in the same cycle DONE is asserted is ignored; a new START is accepted from IDLE the following cycle.
- W=1 case: the first beat has LAST=1.
- Counter width is $clog2(W+1) bits, and the counter never underflows.
- The design is synthesizable, a single clock domain, and uses no latches.

Optional Feature:
- Macro SER_TX_PARITY_EN.
- Defined:
  - After the W data beats, one extra beat carries A_BIT = XOR-reduce of the captured A, and B_BIT = XOR-reduce of the captured B.
  - Parity is computed at capture time.
  - LAST is asserted on the parity beat only, not on the final data beat.
  - Backpressure rules are identical to data beats.
- Undefined: no parity logic; exactly W beats; LAST is on data beat W.

Test Plan:
- Reset behaviour: RST pulse asynchronous to CLK mid-SHIFT (W=8, A=8'hA5, after 3 beats) -> all outputs 0 immediately; IDLE after release; no DONE.
- Basic transfer: W=8, A_IN=8'hA5, B_IN=8'h3C, START 1 cycle, READY=1 -> A_BIT sequence 1,0,1,0,0,1,0,1 and B_BIT sequence 0,0,1,1,1,1,0,0 on consecutive cycles; LAST on the 8th beat; DONE 9 cycles after START sampled.
- Backpressure: same operands with READY=0 for 3 cycles after beat 2 -> beat 3 values and VALID held stable for all 3 cycles; no beat lost or duplicated; DONE delayed by exactly 3 cycles.
- Ignored START: START pulsed during SHIFT with A_IN=8'hFF -> transmitted data still 8'hA5; START in the DONE cycle ignored; START the next cycle accepted.
- Narrow width: W=1, A_IN=1, B_IN=0 -> single beat with LAST=1, A_BIT=1, B_BIT=0; DONE next cycle.
- Parity (SER_TX_PARITY_EN defined): A=8'hA5, B=8'h3D -> 9 beats; LAST only on beat 9; beat 9 has A_BIT=0, B_BIT=1.
